mm_feeder: RTL and testbench

- Master-side source for the MM matrix-multiply input interface. It replaces the bench stimulus with synthesizable logic.
- Per test case it streams MAT_NUM matrices from a shape memory and a data memory. Each matrix is sent row-major on in_data, with col_end and row_end framing and busy back-pressure.
- It sits between the test-pattern SRAMs and MM in the on-chip self-test wrapper.

---
 rtl/mm_feeder.sv | 249 ++++++++++++++++++++++++
 tb/tb_mm_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_feeder.sv
// mm_feeder: reads matrix shapes and elements from the test-pattern SRAMs and
// streams MAT_NUM matrices row-major to MM with col_end/row_end framing.
// Data reads run ahead through a 2-entry buffer so a matrix streams without
// bubbles while busy is low, and fetching stops exactly at the last element.
module mm_feeder #(
  parameter int DW      = 8,
  parameter int AW      = 20,
  parameter int SAW     = 20,
  parameter int MAT_NUM = 3,
  parameter int MAXR    = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AW-1:0]  data_base,
  input  logic [SAW-1:0] shp_base,
  output logic [SAW-1:0] shp_addr,
  output logic           shp_ren,
  input  logic [3:0]     shp_rdata,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_ren,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           busy,
  output logic [DW-1:0]  in_data,
  output logic           col_end,
  output logic           row_end,
  output logic           in_vld,
  output logic           done,
  output logic [SAW-1:0] shp_next,
  output logic [AW-1:0]  data_next
);

  localparam int MIW = (MAT_NUM > 1) ? $clog2(MAT_NUM) : 1;

  typedef enum logic [2:0] {IDLE, SHP_R, SHP_C, PREF, STREAM, GAP} state_t;

  state_t state, state_nx;

  logic [SAW-1:0] shp_ptr;
  logic [AW-1:0]  data_ptr;
  logic [MIW-1:0] mat_idx;
  logic           mat_last;
  logic           mat_begin;

  logic [3:0]     num_rows;
  logic [3:0]     col_tab [MAXR];
  logic [3:0]     rd_cnt;
  logic [3:0]     wr_cnt;
  logic           shp_pend;

  logic [3:0]     f_row;
  logic [3:0]     f_col;
  logic [3:0]     fetch_width;
  logic           fetch_last;
  logic           fetch_done;
  logic           mem_pend;

  logic [DW-1:0]  buf_q [2];
  logic           buf_rp;
  logic           buf_wp;
  logic [1:0]     buf_cnt;
  logic [1:0]     occ;

  logic [3:0]     col_cnt;
  logic [3:0]     row_cnt;
  logic [3:0]     row_width;
  logic [3:0]     gap_cnt;
  logic           consume;

  // A shape entry of zero still means one row or one column.
  function automatic logic [3:0] clamp1(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  assign mat_last    = (mat_idx == MIW'(MAT_NUM - 1));
  assign row_width   = col_tab[row_cnt];
  assign fetch_width = col_tab[f_row];
  assign fetch_last  = (f_row == num_rows - 4'd1) && (f_col == fetch_width - 4'd1);
  assign occ         = buf_cnt + {1'b0, mem_pend};

  assign in_vld  = (state == STREAM) && (buf_cnt != 2'd0);
  assign consume = in_vld && !busy;
  assign col_end = in_vld && (col_cnt == row_width - 4'd1);
  assign row_end = col_end && (row_cnt == num_rows - 4'd1);
  assign in_data = in_vld ? buf_q[buf_rp] : '0;

  assign shp_addr  = shp_ren ? shp_ptr : '0;
  assign mem_addr  = mem_ren ? data_ptr : '0;
  assign shp_next  = shp_ptr;
  assign data_next = data_ptr;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state plus read enables, done pulse and per-matrix restart strobe.
  always_comb begin
    state_nx  = state;
    shp_ren   = 1'b0;
    mem_ren   = 1'b0;
    done      = 1'b0;
    mat_begin = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = SHP_R;
          mat_begin = 1'b1;
        end
      end
      SHP_R: begin
        shp_ren = !shp_pend;
        if (shp_pend) state_nx = SHP_C;
      end
      SHP_C: begin
        shp_ren = (rd_cnt < num_rows);
        if (shp_pend && (wr_cnt == num_rows - 4'd1)) state_nx = PREF;
      end
      PREF: begin
        mem_ren = !fetch_done && (occ < 2'd2);
        if ((buf_cnt == 2'd2) || (fetch_done && !mem_pend && (buf_cnt != 2'd0)))
          state_nx = STREAM;
      end
      STREAM: begin
        mem_ren = !fetch_done && ((occ < 2'd2) || ((occ == 2'd2) && consume));
        if (consume && row_end) state_nx = GAP;
      end
      GAP: begin
        if (mat_last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (gap_cnt == num_rows - 4'd1) begin
          state_nx  = SHP_R;
          mat_begin = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory pointers and matrix index; bases are captured only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shp_ptr  <= '0;
      data_ptr <= '0;
      mat_idx  <= '0;
    end else if ((state == IDLE) && start) begin
      shp_ptr  <= shp_base;
      data_ptr <= data_base;
      mat_idx  <= '0;
    end else begin
      if (shp_ren)   shp_ptr  <= shp_ptr + 1'b1;
      if (mem_ren)   data_ptr <= data_ptr + 1'b1;
      if (mat_begin) mat_idx  <= mat_idx + 1'b1;
    end
  end

  // Shape loader: row count first, then one column count per row into col_tab.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shp_pend <= 1'b0;
      num_rows <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      for (int i = 0; i < MAXR; i++) col_tab[i] <= '0;
    end else begin
      shp_pend <= shp_ren;
      if (mat_begin) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if ((state == SHP_R) && shp_pend) num_rows <= clamp1(shp_rdata);
        if ((state == SHP_C) && shp_ren) rd_cnt <= rd_cnt + 4'd1;
        if ((state == SHP_C) && shp_pend) begin
          col_tab[wr_cnt] <= clamp1(shp_rdata);
          wr_cnt          <= wr_cnt + 4'd1;
        end
      end
    end
  end

  // Fetch position tracks which element the next data read belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_row      <= '0;
      f_col      <= '0;
      fetch_done <= 1'b0;
      mem_pend   <= 1'b0;
    end else begin
      mem_pend <= mem_ren;
      if (mat_begin) begin
        f_row      <= '0;
        f_col      <= '0;
        fetch_done <= 1'b0;
      end else if (mem_ren) begin
        if (fetch_last) begin
          fetch_done <= 1'b1;
        end else if (f_col == fetch_width - 4'd1) begin
          f_col <= '0;
          f_row <= f_row + 4'd1;
        end else begin
          f_col <= f_col + 4'd1;
        end
      end
    end
  end

  // Two-entry prefetch buffer: filled the cycle after a read, drained on consumption.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_rp   <= 1'b0;
      buf_wp   <= 1'b0;
      buf_cnt  <= '0;
    end else begin
      if (mem_pend) begin
        buf_q[buf_wp] <= mem_rdata;
        buf_wp        <= ~buf_wp;
      end
      if (consume) buf_rp <= ~buf_rp;
      buf_cnt <= buf_cnt + {1'b0, mem_pend} - {1'b0, consume};
    end
  end

  // Consumption counters drive framing; the gap counter paces inter-matrix spacing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (mat_begin) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (consume) begin
        if (col_end) begin
          col_cnt <= '0;
          if (!row_end) row_cnt <= row_cnt + 4'd1;
        end else begin
          col_cnt <= col_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mm_feeder.sv
// tb_mm_feeder: directed bench for mm_feeder with behavioural shape/data SRAMs.
// Data memory holds addr+0x11 so every expected element follows from the base.
module tb_mm_feeder;

  localparam int DW  = 8;
  localparam int AW  = 20;
  localparam int SAW = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  data_base;
  logic [SAW-1:0] shp_base;
  logic [SAW-1:0] shp_addr;
  logic           shp_ren;
  logic [3:0]     shp_rdata;
  logic [AW-1:0]  mem_addr;
  logic           mem_ren;
  logic [DW-1:0]  mem_rdata;
  logic           busy;
  logic [DW-1:0]  in_data;
  logic           col_end;
  logic           row_end;
  logic           in_vld;
  logic           done;
  logic [SAW-1:0] shp_next;
  logic [AW-1:0]  data_next;

  logic [3:0]     shp_mem  [256];
  logic [7:0]     data_mem [256];

  logic [7:0]     beat_data  [$];
  logic           beat_ce    [$];
  logic           beat_re    [$];
  int             beat_cyc   [$];
  int             beat_reads [$];

  int             cyc      = 0;
  int             read_cnt = 0;
  int             done_cnt = 0;

  int             checks = 0;
  int             errors = 0;
  int             beat_base;
  int             reads_base;
  int             done_base;
  int             done_cyc;
  logic [SAW-1:0] nx_shp;
  logic [AW-1:0]  nx_data;

  mm_feeder #(.DW(DW), .AW(AW), .SAW(SAW), .MAT_NUM(3), .MAXR(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_base (data_base),
    .shp_base  (shp_base),
    .shp_addr  (shp_addr),
    .shp_ren   (shp_ren),
    .shp_rdata (shp_rdata),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .in_data   (in_data),
    .col_end   (col_end),
    .row_end   (row_end),
    .in_vld    (in_vld),
    .done      (done),
    .shp_next  (shp_next),
    .data_next (data_next)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time done against the last beat.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read SRAM models: data valid the cycle after the enable.
  always @(posedge clk) begin
    if (shp_ren) shp_rdata <= shp_mem[shp_addr[7:0]];
    if (mem_ren) mem_rdata <= data_mem[mem_addr[7:0]];
  end

  // Monitor: logs every consumed beat, read count and done pulse at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_ren) read_cnt <= read_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (in_vld && !busy) begin
        beat_data.push_back(in_data);
        beat_ce.push_back(col_end);
        beat_re.push_back(row_end);
        beat_cyc.push_back(cyc);
        beat_reads.push_back(read_cnt);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_shapes(input int base, input int n, input logic [63:0] nib);
    for (int i = 0; i < n; i++) shp_mem[base + i] = nib[4*(n-1-i) +: 4];
  endtask

  task automatic apply_stimulus(input logic [SAW-1:0] sb, input logic [AW-1:0] db);
    @(posedge clk); #1;
    beat_base  = beat_data.size();
    reads_base = read_cnt;
    done_base  = done_cnt;
    shp_base   = sb;
    data_base  = db;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok       = 1'b1;
        done_cyc = cyc;
        nx_shp   = shp_next;
        nx_data  = data_next;
        break;
      end
    end
    check_output({tag, "_done_seen"}, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_vld(input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_vld) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({tag, "_vld_seen"}, ok, 1);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [7:0] first,
                             input logic [15:0] ce_mask, input logic [15:0] re_mask);
    int got;
    got = beat_data.size() - beat_base;
    check_output({tag, "_beat_count"}, got, n);
    for (int j = 0; j < n; j++) begin
      if (beat_base + j < beat_data.size())
        check_output($sformatf("%s_beat%0d", tag, j),
                     {beat_data[beat_base+j], beat_ce[beat_base+j], beat_re[beat_base+j]},
                     {8'(first + j), ce_mask[j], re_mask[j]});
    end
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_flags"}, {in_vld, col_end, row_end, done, shp_ren, mem_ren}, 0);
    check_output({tag, "_in_data"}, in_data, 0);
    check_output({tag, "_addrs"}, {shp_addr, mem_addr}, 0);
    check_output({tag, "_next"}, {shp_next, data_next}, 0);
  endtask

  // Directed sequence: reset, nominal run, busy stalls, ragged rows, start
  // during streaming, back-to-back chaining, 1x1 matrices and mid-run reset.
  initial begin
    logic       pat [4];
    int         k;
    int         got;
    logic       ok;

    rst       = 1'b0;
    start     = 1'b0;
    busy      = 1'b0;
    data_base = '0;
    shp_base  = '0;
    for (int i = 0; i < 256; i++) begin
      data_mem[i] = 8'(i + 8'h11);
      shp_mem[i]  = 4'd0;
    end
    load_shapes('h00, 10, 64'h2333222222);
    load_shapes('h20, 7,  64'h2331111);
    load_shapes('h30, 8,  64'h32311111);
    load_shapes('h38, 6,  64'h111111);

    repeat (2) @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] case 1: shapes 2x3, 3x2, 2x2, busy low");
    apply_stimulus('h00, 'h00);
    wait_done(400, "c1");
    check_beats("c1", 16, 8'h11, 16'hAAA4, 16'h8820);
    if (beat_data.size() >= beat_base + 16)
      check_output("c1_done_latency", done_cyc - beat_cyc[beat_base+15], 1);
    check_output("c1_shp_next", nx_shp, 'h0A);
    check_output("c1_data_next", nx_data, 'h10);
    check_output("c1_done_count", done_cnt - done_base, 1);

    $display("[TB] case 2: 2x3 with busy stalls");
    busy = 1'b1;
    apply_stimulus('h20, 'h00);
    wait_vld(200, "c2");
    check_output("c2_hold_first", {in_vld, col_end, row_end, in_data}, {3'b100, 8'h11});
    pat = '{1'b0, 1'b1, 1'b1, 1'b0};
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy == 1'b0) k++;
      busy = pat[i];
      @(negedge clk);
      check_output($sformatf("c2_stall%0d", i), {in_vld, col_end, row_end, in_data},
                   {3'b100, 8'(8'h11 + k)});
    end
    wait_done(400, "c2");
    check_beats("c2", 8, 8'h11, 16'h00E4, 16'h00E0);
    check_output("c2_next", {nx_shp, nx_data}, {20'h00027, 20'h00008});

    $display("[TB] case 3: ragged rows, start pulsed while streaming");
    apply_stimulus('h30, 'h40);
    wait_vld(200, "c3");
    @(posedge clk); #1;
    shp_base  = 'h00;
    data_base = 'h00;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done(400, "c3");
    check_beats("c3", 8, 8'h51, 16'h00F2, 16'h00E0);
    if (beat_data.size() >= beat_base + 6)
      check_output("c3_reads_at_row_end", beat_reads[beat_base+5] - reads_base, 6);
    check_output("c3_reads_total", read_cnt - reads_base, 8);
    check_output("c3_shp_next", nx_shp, 'h38);
    check_output("c3_data_next", nx_data, 'h48);

    $display("[TB] case 4: chained from next addresses, 1x1 matrices");
    apply_stimulus(nx_shp, nx_data);
    wait_done(200, "c4");
    check_beats("c4", 3, 8'h59, 16'h0007, 16'h0007);
    check_output("c4_reads_total", read_cnt - reads_base, 3);
    check_output("c4_next", {nx_shp, nx_data}, {20'h0003E, 20'h0004B});

    $display("[TB] case 5: reset during second matrix, then replay");
    apply_stimulus('h00, 'h00);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      got = beat_data.size() - beat_base;
      if (got >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("c5_reach_mid", ok, 1);
    rst = 1'b0;
    #1;
    check_cleared("c5_async");
    repeat (4) @(posedge clk);
    #1;
    check_cleared("c5_held");
    check_output("c5_no_done", done_cnt - done_base, 0);
    rst = 1'b1;
    apply_stimulus('h00, 'h10);
    wait_done(400, "c5");
    check_beats("c5", 16, 8'h21, 16'hAAA4, 16'h8820);
    check_output("c5_next", {nx_shp, nx_data}, {20'h0000A, 20'h00020});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
